// File: rtl/sr_ctrl_pkg.sv
// sr_ctrl_pkg: op encodings and a one-hot to index helper for the flag arbiter
package sr_ctrl_pkg;
  localparam logic OP_RESET = 1'b0;
  localparam logic OP_SET = 1'b1;
  function automatic logic [31:0] onehot_to_idx(input logic [31:0] oh);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r = oh[i] ? (r | 32'(i)) : r;
    return r;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; ports req, ptr (start position) -> grant (one-hot), grant_valid
module rr_arbiter #(
  parameter int N = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          grant_valid
);
  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++)
      if (grant == '0 && req[(int'(ptr) + i) % N]) grant[(int'(ptr) + i) % N] = 1'b1;
  end
  assign grant_valid = |req;
endmodule

// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter: round-robin shared set/reset flag bank; ports clk, rst (async), clr_all, req/req_set/req_idx -> gnt, flags, flags_bar, busy [+ conflict, conflict_idx when SR_CONFLICT_DETECT_EN]
module sr_flag_arbiter
  import sr_ctrl_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int NFLAG = 8,
  parameter int IDXW = $clog2(NFLAG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_all,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_set,
  input  logic [NREQ*IDXW-1:0] req_idx,
  output logic [NREQ-1:0]      gnt,
  output logic [NFLAG-1:0]     flags,
  output logic [NFLAG-1:0]     flags_bar,
`ifdef SR_CONFLICT_DETECT_EN
  output logic                 conflict,
  output logic [IDXW-1:0]      conflict_idx,
`endif
  output logic                 busy
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  logic [NREQ-1:0] elig, win;
  logic win_v;
  logic [PW-1:0] ptr, w;
  logic [IDXW-1:0] widx;
  logic [NFLAG-1:0] mask;
  // a requester granted last cycle sits out this cycle, so one handshake applies once
  assign elig = req & ~gnt;
  rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (.req(elig), .ptr(ptr), .grant(win), .grant_valid(win_v));
  assign w = PW'(onehot_to_idx(32'(win)));
  assign widx = req_idx[int'(w)*IDXW +: IDXW];
  // an out-of-range index shifts the bit out, leaving an empty mask
  assign mask = NFLAG'(1) << widx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      flags <= '0;
      gnt <= '0;
      ptr <= '0;
    end else if (clr_all) begin
      flags <= '0;
      gnt <= '0;
    end else begin
      gnt <= win;
      if (win_v) begin
        ptr <= (int'(w) == NREQ - 1) ? '0 : w + 1'b1;
        flags <= (req_set[w] == OP_SET) ? (flags | mask) : (flags & ~mask);
      end
    end
  assign flags_bar = ~flags;
  assign busy = |elig;
`ifdef SR_CONFLICT_DETECT_EN
  logic cf;
  logic [IDXW-1:0] cidx;
  always_comb begin
    cf = 1'b0;
    cidx = '0;
    for (int i = 0; i < NREQ; i++)
      for (int j = i + 1; j < NREQ; j++)
        if (elig[i] && elig[j] && req_idx[i*IDXW +: IDXW] == req_idx[j*IDXW +: IDXW] &&
            req_set[i] != req_set[j] && int'(req_idx[i*IDXW +: IDXW]) < NFLAG) begin
          cidx = (!cf || req_idx[i*IDXW +: IDXW] < cidx) ? req_idx[i*IDXW +: IDXW] : cidx;
          cf = 1'b1;
        end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      conflict <= 1'b0;
      conflict_idx <= '0;
    end else begin
      conflict <= cf;
      conflict_idx <= cf ? cidx : conflict_idx;
    end
`endif
endmodule
